// File: rtl/oflow_fe_stream_if.sv
// Handshake bundle for the optical-flow feature-extraction stream: the
// record input channel and the result output channel with its side-band outputs.
interface oflow_fe_stream_if #(
    parameter int COORD_W = 11,
    parameter int COLOR_W = 24,
    parameter int HIST_W  = 8,
    parameter int ID_W    = 6,
    parameter int BBOX_W  = 4*COORD_W + 2*COLOR_W + HIST_W
) ();
    // Record input channel.
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_sof;
    logic [BBOX_W-1:0]      bbox;

    // Result output channel (FIFO head).
    logic                   out_valid;
    logic                   out_ready;
    logic [2*COORD_W-1:0]   cm_concate;
    logic [4*COORD_W-1:0]   position_concate;
    logic [COORD_W-1:0]     width;
    logic [COORD_W-1:0]     height;
    logic [COLOR_W-1:0]     color1;
    logic [COLOR_W-1:0]     color2;
    logic [HIST_W-1:0]      d_history;
    logic [ID_W-1:0]        obj_id;
    logic                   out_clipped;
    logic [7:0]             drop_count;

    // The block itself: consumes records, produces results.
    modport slave (
        input  in_valid, in_sof, bbox, out_ready,
        output in_ready, out_valid, cm_concate, position_concate, width, height,
               color1, color2, d_history, obj_id, out_clipped, drop_count
    );

    // The environment around the block: produces records, consumes results.
    modport master (
        output in_valid, in_sof, bbox, out_ready,
        input  in_ready, out_valid, cm_concate, position_concate, width, height,
               color1, color2, d_history, obj_id, out_clipped, drop_count
    );
endinterface

// File: rtl/oflow_fe_stream.sv
// Streaming feature extraction: registers each accepted bounding box (S1),
// then computes centre of mass and frame-clipped corners, tags a per-frame
// object ID and writes the result into a show-ahead output FIFO. Zero-size
// boxes are counted and discarded. Input credit is derived from FIFO
// occupancy plus the S1 slot so the FIFO can never overflow.
module oflow_fe_stream #(
    parameter int COORD_W    = 11,
    parameter int COLOR_W    = 24,
    parameter int HIST_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int FRAME_W    = 1920,
    parameter int FRAME_H    = 1080,
    parameter int ID_W       = 6,
    parameter int BBOX_W     = 4*COORD_W + 2*COLOR_W + HIST_W
) (
    input  logic              clk,
    input  logic              reset,
    oflow_fe_stream_if.slave  bus
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 8*COORD_W + 2*COLOR_W + HIST_W + ID_W + 1;

    // Stage-1 and FIFO state.
    logic                   s1_valid_reg, s1_sof_reg;
    logic [BBOX_W-1:0]      s1_bbox_reg, s1_bbox_next;
    logic [CNT_W-1:0]       count_reg, count_next;
    logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [ID_W-1:0]        id_cnt_reg, id_cnt_next, id_base;
    logic [7:0]             drop_cnt_reg, drop_cnt_next, drop_base;
    logic                   in_ready_reg, in_ready_next;
    logic [ENTRY_W-1:0]     mem [FIFO_DEPTH];

    logic accept, push, pop, size_zero;

    // Unpacked S1 record fields.
    logic [COORD_W-1:0] f_x, f_y, f_w, f_h;
    logic [COLOR_W-1:0] f_c1, f_c2;
    logic [HIST_W-1:0]  f_hist;
    assign {f_x, f_y, f_w, f_h, f_c1, f_c2, f_hist} = s1_bbox_reg;

    // Per-axis view: index 0 is x/width, index 1 is y/height.
    logic [COORD_W-1:0] org_v [2];
    logic [COORD_W-1:0] ext_v [2];
    logic [COORD_W-1:0] cm_v  [2];
    logic [COORD_W-1:0] p1_v  [2];
    logic [COORD_W-1:0] p2_v  [2];
    logic [1:0]         clip_v;

    assign org_v[0] = f_x;
    assign org_v[1] = f_y;
    assign ext_v[0] = f_w;
    assign ext_v[1] = f_h;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            localparam logic [COORD_W:0] LIM_E = (gi == 0) ? (COORD_W+1)'(FRAME_W - 1)
                                                            : (COORD_W+1)'(FRAME_H - 1);
            logic [COORD_W:0] a1, a2;
            // Far corner needs the extra bit: origin + extent can exceed the coordinate range.
            assign a1 = {1'b0, org_v[gi]};
            assign a2 = {1'b0, org_v[gi]} + {1'b0, ext_v[gi]} - (COORD_W+1)'(1);
            // Centre of mass wraps at the coordinate width and is never clipped.
            assign cm_v[gi]   = org_v[gi] + (ext_v[gi] >> 1);
            assign p1_v[gi]   = (a1 > LIM_E) ? LIM_E[COORD_W-1:0] : a1[COORD_W-1:0];
            assign p2_v[gi]   = (a2 > LIM_E) ? LIM_E[COORD_W-1:0] : a2[COORD_W-1:0];
            assign clip_v[gi] = (a1 > LIM_E) || (a2 > LIM_E);
        end
    endgenerate

    assign accept    = bus.in_valid && in_ready_reg;
    assign size_zero = (f_w == '0) || (f_h == '0);
    assign push      = s1_valid_reg && !size_zero;
    assign pop       = (count_reg != '0) && bus.out_ready;
    assign id_base   = s1_sof_reg ? '0 : id_cnt_reg;
    assign drop_base = s1_sof_reg ? 8'd0 : drop_cnt_reg;

    assign s1_bbox_next  = accept ? bus.bbox : s1_bbox_reg;
    assign count_next    = count_reg + CNT_W'(push) - CNT_W'(pop);
    // Credit looks at next-state occupancy, so a pop frees a slot one cycle later.
    assign in_ready_next = ({1'b0, count_next} + (CNT_W+1)'(accept)) < (CNT_W+1)'(FIFO_DEPTH);

    // Frame bookkeeping: object ID consumed only by written records, drops counted per frame.
    always_comb begin
        id_cnt_next   = id_cnt_reg;
        drop_cnt_next = drop_cnt_reg;
        if (s1_valid_reg) begin
            id_cnt_next   = push ? id_base + ID_W'(1) : id_base;
            drop_cnt_next = !size_zero ? drop_base :
                            (drop_base == 8'hFF) ? 8'hFF : drop_base + 8'd1;
        end
    end

    // Control state, cleared asynchronously so a reset flushes everything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_sof_reg   <= 1'b0;
            s1_bbox_reg  <= '0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            id_cnt_reg   <= '0;
            drop_cnt_reg <= '0;
            in_ready_reg <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            s1_sof_reg   <= accept && bus.in_sof;
            s1_bbox_reg  <= s1_bbox_next;
            count_reg    <= count_next;
            wr_ptr_reg   <= push ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
            rd_ptr_reg   <= pop  ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
            id_cnt_reg   <= id_cnt_next;
            drop_cnt_reg <= drop_cnt_next;
            in_ready_reg <= in_ready_next;
        end
    end

    // FIFO storage write; contents need no reset because the head is gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {cm_v[0], cm_v[1], p1_v[0], p1_v[1], p2_v[0], p2_v[1],
                                f_w, f_h, f_c1, f_c2, f_hist, id_base, |clip_v};
        end
    end

    // Show-ahead head: fields are zero whenever the FIFO is empty.
    logic [ENTRY_W-1:0] head;
    assign head = (count_reg != '0) ? mem[rd_ptr_reg] : '0;

    assign {bus.cm_concate, bus.position_concate, bus.width, bus.height,
            bus.color1, bus.color2, bus.d_history, bus.obj_id, bus.out_clipped} = head;
    assign bus.out_valid  = (count_reg != '0);
    assign bus.in_ready   = in_ready_reg;
    assign bus.drop_count = drop_cnt_reg;
endmodule

// File: tb/tb_oflow_fe_stream.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// outputs compared against a behavioural queue model of the stream.
module tb_oflow_fe_stream;
    localparam int BW = 100;

    logic clk;
    logic reset;
    oflow_fe_stream_if bus ();

    oflow_fe_stream dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [21:0] cm;
        logic [43:0] pos;
        logic [5:0]  id;
        logic [78:0] misc;
    } exp_t;

    exp_t exp_q[$];
    int   model_id, model_drop;
    int   checks, failures;
    int   n_acc, n_pop;
    int   last_id;
    bit   last_acc;

    task automatic check(string tag, logic [127:0] obs, logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [BW-1:0] pack(int x, int y, int w, int h, int c1, int c2, int hist);
        return {11'(x), 11'(y), 11'(w), 11'(h), 24'(c1), 24'(c2), 8'(hist)};
    endfunction

    function automatic logic [BW-1:0] rnd_bbox(bit allow_zero);
        int w, h;
        w = $urandom_range(1, 400);
        h = $urandom_range(1, 400);
        if (allow_zero && $urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 0) w = 0; else h = 0;
        end
        return pack($urandom_range(0, 2047), $urandom_range(0, 2047), w, h,
                    int'($urandom), int'($urandom), int'($urandom));
    endfunction

    function automatic int clampi(int v, int lim);
        return (v > lim) ? lim : v;
    endfunction

    // Reference behaviour of one accepted record.
    task automatic model_accept(bit sof, logic [BW-1:0] b);
        int x, y, w, h, x2, y2;
        exp_t e;
        x = int'(b[99:89]); y = int'(b[88:78]); w = int'(b[77:67]); h = int'(b[66:56]);
        if (sof) begin
            model_id   = 0;
            model_drop = 0;
        end
        if (w == 0 || h == 0) begin
            model_drop = (model_drop >= 255) ? 255 : model_drop + 1;
            return;
        end
        x2 = x + w - 1;
        y2 = y + h - 1;
        e.cm   = {11'((x + w / 2) % 2048), 11'((y + h / 2) % 2048)};
        e.pos  = {11'(clampi(x, 1919)), 11'(clampi(y, 1079)),
                  11'(clampi(x2, 1919)), 11'(clampi(y2, 1079))};
        e.id   = 6'(model_id);
        e.misc = {b[77:56], b[55:0], (x > 1919 || x2 > 1919 || y > 1079 || y2 > 1079)};
        model_id = (model_id + 1) % 64;
        exp_q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        check("spurious_output", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check("cm", 128'(bus.cm_concate), 128'(e.cm));
        check("position", 128'(bus.position_concate), 128'(e.pos));
        check("obj_id", 128'(bus.obj_id), 128'(e.id));
        check("passthru_clip", 128'({bus.width, bus.height, bus.color1, bus.color2,
                                     bus.d_history, bus.out_clipped}), 128'(e.misc));
        last_id = int'(bus.obj_id);
        n_pop++;
        $display("OUT id=%0d cm=%h pos=%h clip=%0b drops=%0d", bus.obj_id, bus.cm_concate,
                 bus.position_concate, bus.out_clipped, bus.drop_count);
    endtask

    // One clock cycle: sample handshakes mid-cycle, then move to just after the next edge.
    task automatic tick();
        bit acc, pp;
        #2;
        acc = bus.in_valid && bus.in_ready;
        pp  = bus.out_valid && bus.out_ready;
        if (pp) check_pop();
        if (acc) begin
            model_accept(bus.in_sof, bus.bbox);
            n_acc++;
        end
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit v, bit sof, logic [BW-1:0] b);
        bus.in_valid = v;
        bus.in_sof   = sof;
        bus.bbox     = b;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i >= 3 && exp_q.size() == 0 && !bus.out_valid) break;
        end
        check("drain_model_empty", 128'(exp_q.size()), 128'(0));
        check("drain_out_valid", 128'(bus.out_valid), 128'(0));
        check("drain_drop_count", 128'(bus.drop_count), 128'(model_drop));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, pop0, bubbles, stalls;
        checks = 0; failures = 0; n_acc = 0; n_pop = 0;
        model_id = 0; model_drop = 0; last_id = -1; last_acc = 0;
        reset = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, 1'b0, '0);

        // Reset state.
        #8;
        check("rst_in_ready", 128'(bus.in_ready), 128'(0));
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_drop_count", 128'(bus.drop_count), 128'(0));
        check("rst_fields", 128'({bus.cm_concate, bus.position_concate, bus.obj_id}), 128'(0));
        #4;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rel_in_ready", 128'(bus.in_ready), 128'(1));

        // Basic record with two-edge latency.
        drive(1'b1, 1'b1, pack(500, 250, 20, 30, 'h100, 'h100, 8));
        tick();
        drive(1'b0, 1'b0, '0);
        check("lat_not_yet", 128'(bus.out_valid), 128'(0));
        tick();
        check("lat_valid", 128'(bus.out_valid), 128'(1));
        check("basic_cm", 128'(bus.cm_concate), 128'({11'd510, 11'd265}));
        check("basic_pos", 128'(bus.position_concate), 128'({11'd500, 11'd250, 11'd519, 11'd279}));
        check("basic_wh", 128'({bus.width, bus.height}), 128'({11'd20, 11'd30}));
        check("basic_id_clip", 128'({bus.obj_id, bus.out_clipped}), 128'({6'd0, 1'b0}));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Clipping at the frame edges.
        drive(1'b1, 1'b0, pack(1910, 1070, 20, 30, 'h123456, 'h654321, 3));
        tick();
        drive(1'b0, 1'b0, '0);
        tick();
        check("clip_pos", 128'(bus.position_concate), 128'({11'd1910, 11'd1070, 11'd1919, 11'd1079}));
        check("clip_cm", 128'(bus.cm_concate), 128'({11'd1920, 11'd1085}));
        check("clip_flag_id", 128'({bus.out_clipped, bus.obj_id}), 128'({1'b1, 6'd1}));
        drain();

        // Zero-size record between two valid records, then a new frame.
        pop0 = n_pop;
        drive(1'b1, 1'b1, pack(100, 100, 10, 10, 1, 2, 3));
        tick();
        drive(1'b1, 1'b0, pack(200, 200, 0, 10, 4, 5, 6));
        tick();
        drive(1'b1, 1'b0, pack(300, 300, 12, 14, 7, 8, 9));
        tick();
        drain();
        check("drop_outputs", 128'(n_pop - pop0), 128'(2));
        check("drop_last_id", 128'(last_id), 128'(1));
        check("drop_count_one", 128'(bus.drop_count), 128'(1));
        drive(1'b1, 1'b1, pack(400, 400, 16, 16, 1, 1, 1));
        tick();
        drain();
        check("sof_drop_clear", 128'(bus.drop_count), 128'(0));
        check("sof_id_restart", 128'(last_id), 128'(0));

        // Backpressure: FIFO plus S1 credit admits exactly four records.
        bus.out_ready = 1'b0;
        acc0 = n_acc;
        drive(1'b1, 1'b0, rnd_bbox(1'b0));
        for (int i = 0; i < 8; i++) begin
            tick();
            if (last_acc) bus.bbox = rnd_bbox(1'b0);
        end
        check("bp_accepted", 128'(n_acc - acc0), 128'(4));
        check("bp_in_ready_low", 128'(bus.in_ready), 128'(0));
        drive(1'b0, 1'b0, '0);
        bus.out_ready = 1'b1;
        tick();
        check("bp_ready_back", 128'(bus.in_ready), 128'(1));
        drain();

        // Streaming: 70 back-to-back records, IDs wrap past 63.
        acc0 = n_acc; bubbles = 0; stalls = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 70; i++) begin
            drive(1'b1, i == 0, rnd_bbox(1'b0));
            if (i >= 2 && !bus.out_valid) bubbles++;
            if (!bus.in_ready) stalls++;
            tick();
        end
        check("stream_accepted", 128'(n_acc - acc0), 128'(70));
        check("stream_bubbles", 128'(bubbles), 128'(0));
        check("stream_stalls", 128'(stalls), 128'(0));
        drain();
        check("stream_wrap_last_id", 128'(last_id), 128'(5));

        // Reset with three records buffered.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, rnd_bbox(1'b0));
            tick();
        end
        drive(1'b0, 1'b0, '0);
        tick();
        tick();
        check("mid_buffered", 128'(bus.out_valid), 128'(1));
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("mid_rst_in_ready", 128'(bus.in_ready), 128'(0));
        exp_q.delete();
        model_id = 0;
        model_drop = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("mid_no_stale", 128'(bus.out_valid), 128'(0));
        check("mid_drop_zero", 128'(bus.drop_count), 128'(0));
        drive(1'b1, 1'b0, pack(50, 60, 8, 8, 1, 2, 3));
        tick();
        drain();
        check("mid_first_id", 128'(last_id), 128'(0));

        // Random traffic with random backpressure, drops and frame starts.
        drive(1'b0, 1'b0, '0);
        for (int i = 0; i < 400; i++) begin
            if (!bus.in_valid || last_acc)
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, rnd_bbox(1'b1));
            bus.out_ready = $urandom_range(0, 1);
            tick();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
